ft_recovery_ctrl: RTL

FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

---
 rtl/ft_pkg.sv | 21 ++
 rtl/ft_recovery_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ft_pkg.sv
// Shared types and constants for the fault-tolerant recovery controller.
// The FAULT state only exists when FT_RETRY_LIMIT_EN is defined.
package ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HALT       = 3'd1,
        ST_RESET      = 3'd2,
        ST_REPLAY     = 3'd3,
        ST_RESTORE_PC = 3'd4,
        ST_RESUME     = 3'd5
`ifdef FT_RETRY_LIMIT_EN
        ,
        ST_FAULT      = 3'd6
`endif
    } ft_rec_state_t;

    // x0 is hard-wired in the cores, so replay starts at register 1
    localparam int FIRST_REPLAY_IDX = 1;

endpackage

// File: rtl/ft_recovery_ctrl.sv
// Lock-step recovery controller: on a comparator mismatch it halts fetch,
// resets the cores, replays the shadow register file into them, restores
// the saved safe PC and resumes.  Errors seen while a recovery is already
// running queue one more recovery behind it.
// Optional feature macro: FT_RETRY_LIMIT_EN -- bounds back-to-back
// recoveries to MAX_RETRIES and then parks in a sticky FAULT state
// flagged on perm_fault_o.
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  error_i,
    input  logic                  halted_i,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  core_we_o,
    output logic [ADDR_WIDTH-1:0] core_waddr_o,
    output logic [DATA_WIDTH-1:0] core_wdata_o,
    input  logic                  core_wready_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  pc_we_o,
    output logic                  halt_o,
    output logic                  reset_o,
    output logic                  resume_o,
    output logic                  busy_o
`ifdef FT_RETRY_LIMIT_EN
    ,
    output logic                  perm_fault_o
`endif
);

    localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCNT_W-1:0]     RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);
    localparam logic [RCNT_W-1:0]     RCNT_ONE  = RCNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(FIRST_REPLAY_IDX);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

    // Reject parameter sets the counters cannot represent
    if (NUM_REGS < 2 || NUM_REGS > (2 ** ADDR_WIDTH) || RESET_CYCLES < 1 || MAX_RETRIES < 0)
    begin : g_param_check
        $error("ft_recovery_ctrl: illegal parameter combination");
    end

    ft_rec_state_t         state;
    ft_rec_state_t         state_nx;
    logic [ADDR_WIDTH-1:0] idx;
    logic [RCNT_W-1:0]     rcnt;
    logic                  pending;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  beat;
    logic                  replay;
    logic                  requeue;

`ifdef FT_RETRY_LIMIT_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
    logic [RETRY_W-1:0] retry_cnt;
`endif

    assign replay  = (state == ST_REPLAY);
    assign beat    = replay && core_wready_i;
    // an error in the RESUME cycle itself still queues another recovery
    assign requeue = pending || error_i;

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (error_i) state_nx = ST_HALT;
            ST_HALT:       if (halted_i) state_nx = ST_RESET;
            ST_RESET:      if (rcnt == RCNT_LAST) state_nx = ST_REPLAY;
            ST_REPLAY:     if (beat && idx == IDX_LAST) state_nx = ST_RESTORE_PC;
            ST_RESTORE_PC: state_nx = ST_RESUME;
            ST_RESUME: begin
                if (!requeue) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_HALT;
`ifdef FT_RETRY_LIMIT_EN
                    if (retry_cnt == RETRY_MAX) state_nx = ST_FAULT;
`endif
                end
            end
`ifdef FT_RETRY_LIMIT_EN
            ST_FAULT:      state_nx = ST_FAULT;
`endif
            default:       state_nx = ST_IDLE;
        endcase
    end

    // State, reset-length counter, replay index and pending flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            rcnt    <= '0;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == ST_RESET && state_nx == ST_RESET) rcnt <= rcnt + RCNT_ONE;
            else                                           rcnt <= '0;

            if (state == ST_RESET && state_nx == ST_REPLAY) idx <= IDX_FIRST;
            else if (beat)                                  idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;

            if (state == ST_RESUME)                 pending <= 1'b0;
            else if (state != ST_IDLE && error_i)   pending <= 1'b1;
        end
    end

    // Restored PC is kept so pc_o holds its value between recoveries
    always_ff @(posedge clk_i) begin
        if (rst_i)                          pc_q <= '0;
        else if (state == ST_RESTORE_PC)    pc_q <= spc_i;
    end

`ifdef FT_RETRY_LIMIT_EN
    // Count back-to-back recoveries; a clean return to IDLE forgives them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_cnt <= '0;
        end else if (state == ST_RESUME) begin
            if (state_nx == ST_HALT)      retry_cnt <= retry_cnt + RETRY_ONE;
            else if (state_nx == ST_IDLE) retry_cnt <= '0;
        end
    end
`endif

    // Outputs are a pure decode of state, so reset clears them in one edge
    always_comb begin
        halt_o       = (state != ST_IDLE);
        busy_o       = (state != ST_IDLE);
        reset_o      = (state == ST_RESET);
        core_we_o    = replay;
        rf_addr_o    = replay ? idx : '0;
        core_waddr_o = replay ? idx : '0;
        core_wdata_o = replay ? rf_rdata_i : '0;
        pc_we_o      = (state == ST_RESTORE_PC);
        pc_o         = (state == ST_RESTORE_PC) ? spc_i : pc_q;
        resume_o     = (state == ST_RESUME);
`ifdef FT_RETRY_LIMIT_EN
        perm_fault_o = (state == ST_FAULT);
        if (state == ST_FAULT) busy_o = 1'b0;
`endif
    end

endmodule
